// File: rtl/game_seq_ctrl.sv
// Round sequencer for the memory game: arms the digit generator, replays the captured digits,
// checks player keys, tracks score/lives. Optional macro INPUT_TIMEOUT_EN adds an input timeout.
module game_seq_ctrl #(
  parameter int N           = 3,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               lfsr_ok,
  input  logic [N:0]         disp0,
  input  logic [N:0]         disp1,
  input  logic [N:0]         disp2,
  input  logic [N:0]         disp3,
  input  logic               key_valid,
  input  logic [N:0]         key_val,
  output logic [3:0]         presente,
  output logic               lfsr_clr,
  output logic               show_valid,
  output logic [N:0]         show_digit,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               win,
  output logic               lose
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_SHOW  = 3'd2,
    S_INPUT = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } st_t;

  localparam int MX1 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MXC = (MX1 > TIMEOUT_CYC) ? MX1 : TIMEOUT_CYC;
  localparam int CW  = $clog2(MXC + 1);

  st_t               st_q, st_d;
  logic [N:0]        seq_q [4];
  logic [N:0]        seq_d [4];
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gap_q, gap_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]        lives_q, lives_d;
  logic              clr_q, clr_d;
  logic              pres_q;
  logic              sv_q, sv_d;
  logic [N:0]        sd_q, sd_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              expire;
  logic              miss;

`ifdef INPUT_TIMEOUT_EN
  logic [CW-1:0]     tcnt_q, tcnt_d;
`endif

  always_comb begin
    st_d    = st_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    score_d = score_q;
    lives_d = lives_q;
    clr_d   = 1'b0;
    sv_d    = sv_q;
    sd_d    = sd_q;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    expire  = 1'b0;
    miss    = 1'b0;
`ifdef INPUT_TIMEOUT_EN
    expire  = (st_q == S_INPUT) && !key_valid && (tcnt_q == '0);
`endif

    case (st_q)
      S_IDLE, S_LOSE: begin
        if (start) begin
          st_d    = S_GEN;
          score_d = '0;
          lives_d = 3'(LIVES);
          clr_d   = 1'b1;
        end
      end
      S_GEN: begin
        // The generator is still held in reset during the clear cycle
        if (lfsr_ok && !clr_q) begin
          seq_d[0] = disp0;
          seq_d[1] = disp1;
          seq_d[2] = disp2;
          seq_d[3] = disp3;
          st_d  = S_SHOW;
          idx_d = 2'd0;
          gap_d = 1'b0;
          cnt_d = CW'(SHOW_CYCLES - 1);
          sv_d  = 1'b1;
          sd_d  = disp0;
        end
      end
      S_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!gap_q) begin
          gap_d = 1'b1;
          cnt_d = CW'(GAP_CYCLES - 1);
          sv_d  = 1'b0;
          sd_d  = '0;
        end else if (idx_q == 2'd3) begin
          st_d  = S_INPUT;
          idx_d = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
          gap_d = 1'b0;
          cnt_d = CW'(SHOW_CYCLES - 1);
          sv_d  = 1'b1;
          sd_d  = seq_q[idx_q + 2'd1];
        end
      end
      S_INPUT: begin
        if (key_valid) begin
          if (key_val == seq_q[idx_q]) begin
            if (idx_q == 2'd3) begin
              if (score_q != '1) score_d = score_q + 1'b1;
              st_d  = S_WIN;
              win_d = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            miss = 1'b1;
          end
        end else if (expire) begin
          miss = 1'b1;
        end
        if (miss) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            st_d   = S_LOSE;
            lose_d = 1'b1;
          end else begin
            st_d  = S_SHOW;
            idx_d = 2'd0;
            gap_d = 1'b0;
            cnt_d = CW'(SHOW_CYCLES - 1);
            sv_d  = 1'b1;
            sd_d  = seq_q[0];
          end
        end
      end
      S_WIN: begin
        st_d  = S_GEN;
        clr_d = 1'b1;
      end
      default: st_d = S_IDLE;
    endcase

    if (st_d != S_SHOW) begin
      sv_d = 1'b0;
      sd_d = '0;
    end
  end

`ifdef INPUT_TIMEOUT_EN
  always_comb begin
    tcnt_d = tcnt_q;
    if (st_d == S_INPUT) begin
      if (st_q != S_INPUT || key_valid || tcnt_q == '0)
        tcnt_d = CW'(TIMEOUT_CYC - 1);
      else
        tcnt_d = tcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= S_IDLE;
      for (int i = 0; i < 4; i++) seq_q[i] <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
      clr_q   <= 1'b0;
      pres_q  <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      score_q <= score_d;
      lives_q <= lives_d;
      clr_q   <= clr_d;
      pres_q  <= (st_d == S_GEN);
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign presente   = {3'b000, pres_q};
  assign lfsr_clr   = clr_q;
  assign show_valid = sv_q;
  assign show_digit = sd_q;
  assign state      = st_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl: full rounds, replays, loss, ignored inputs, score saturation.
module tb_game_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       lfsr_ok = 1'b0;
  logic [3:0] disp0 = '0, disp1 = '0, disp2 = '0, disp3 = '0;
  logic       key_valid = 1'b0;
  logic [3:0] key_val = '0;
  logic [3:0] presente;
  logic       lfsr_clr, show_valid, win, lose;
  logic [3:0] show_digit;
  logic [2:0] state, lives;
  logic [7:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  game_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .lfsr_ok(lfsr_ok),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
    .key_valid(key_valid), .key_val(key_val),
    .presente(presente), .lfsr_clr(lfsr_clr), .show_valid(show_valid),
    .show_digit(show_digit), .state(state), .score(score), .lives(lives),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    key_valid = 1'b1;
    key_val   = v;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int max_cyc);
    int n = 0;
    while (int'(state) != s && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_state", int'(state), s);
  endtask

  // Called in the cycle after lfsr_clr was seen; drives lfsr_ok some cycles later.
  task automatic gen_ok(input int dly, input logic [3:0] a, b, c, d);
    repeat (dly) tick();
    disp0 = a; disp1 = b; disp2 = c; disp3 = d;
    lfsr_ok = 1'b1;
    tick();
    lfsr_ok = 1'b0;
  endtask

  // Entered in the first show cycle; leaves in the first INPUT cycle.
  task automatic check_show(input logic [3:0] a, b, c, d, input bit inject);
    logic [3:0] dg [4];
    dg[0] = a; dg[1] = b; dg[2] = c; dg[3] = d;
    for (int k = 0; k < 4; k++) begin
      for (int c2 = 0; c2 < 4; c2++) begin
        chk("show_valid_on", show_valid, 1);
        chk("show_digit", show_digit, dg[k]);
        if (inject && k == 1 && c2 == 0) begin
          key_valid = 1'b1;
          key_val   = 4'hE;
        end
        tick();
        key_valid = 1'b0;
      end
      for (int g = 0; g < 2; g++) begin
        chk("show_valid_gap", show_valid, 0);
        chk("show_digit_gap", show_digit, 0);
        tick();
      end
    end
    chk("input_entry", state, 3);
  endtask

  task automatic quick_win();
    wait_state(1, 4);
    tick();
    gen_ok(1, 4'h3, 4'h1, 4'h4, 4'h1);
    wait_state(3, 40);
    press(4'h3); press(4'h1); press(4'h4); press(4'h1);
    chk("quick_win_state", state, 4);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_presente", presente, 0);
    chk("rst_show_valid", show_valid, 0);
    chk("rst_lfsr_clr", lfsr_clr, 0);
    reset = 1'b0;
    tick();

    // Round 1
    start = 1'b1; tick(); start = 1'b0;
    chk("gen_state", state, 1);
    chk("gen_clr", lfsr_clr, 1);
    chk("gen_presente", presente, 1);
    lfsr_ok = 1'b1; tick(); lfsr_ok = 1'b0;
    chk("ok_ignored_in_clr", state, 1);
    chk("clr_one_cycle", lfsr_clr, 0);
    chk("gen_presente_hold", presente, 1);
    gen_ok(3, 4'h4, 4'h9, 4'h2, 4'hD);
    chk("show_state", state, 2);
    chk("show_presente", presente, 0);
    check_show(4'h4, 4'h9, 4'h2, 4'hD, 1'b1);
    chk("show_key_lives", lives, 3);
    press(4'h4); press(4'h9); press(4'h2);
    chk("partial_state", state, 3);
    press(4'hD);
    chk("win_state", state, 4);
    chk("win_pulse", win, 1);
    chk("win_score", score, 1);
    tick();
    chk("win_to_gen", state, 1);
    chk("win_clr", lfsr_clr, 1);
    chk("win_pulse_end", win, 0);
    tick();

    // Round 2: mismatches, replay, loss
    gen_ok(2, 4'h1, 4'h0, 4'hF, 4'h6);
    check_show(4'h1, 4'h0, 4'hF, 4'h6, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_input_state", state, 3);
    chk("start_in_input_score", score, 1);
    press(4'h1);
    press(4'h7);
    chk("miss1_lives", lives, 2);
    chk("miss1_state", state, 2);
    check_show(4'h1, 4'h0, 4'hF, 4'h6, 1'b0);
    press(4'h3);
    chk("miss2_lives", lives, 1);
    wait_state(3, 30);
    press(4'h1); press(4'h0); press(4'h5);
    chk("lose_state", state, 5);
    chk("lose_lives", lives, 0);
    chk("lose_pulse", lose, 1);
    tick();
    chk("lose_pulse_end", lose, 0);
    press(4'h1);
    chk("lose_key_ignored", state, 5);
    start = 1'b1; key_valid = 1'b1; key_val = 4'h1;
    tick();
    start = 1'b0; key_valid = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    chk("restart_clr", lfsr_clr, 1);

`ifdef INPUT_TIMEOUT_EN
    tick();
    gen_ok(1, 4'h2, 4'h2, 4'h8, 4'h8);
    wait_state(3, 30);
    repeat (15) tick();
    press(4'h2);
    chk("to_key_accepted_lives", lives, 3);
    chk("to_key_accepted_state", state, 3);
    repeat (15) tick();
    chk("to_not_yet", state, 3);
    tick();
    chk("to_lives", lives, 2);
    chk("to_replay", state, 2);
    wait_state(3, 30);
    press(4'h2); press(4'h2); press(4'h8); press(4'h8);
    chk("to_win", state, 4);
`else
    quick_win();
`endif

    // Saturation: score reaches 255 and holds
    while (int'(score) < 255 && n_bad < 20) quick_win();
    chk("sat_score", score, 255);
    quick_win();
    chk("sat_hold", score, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached, expected finish");
    $fatal(1);
  end

endmodule
